// File: rtl/lane_scatter_16_pkg.sv
// Shared transpose-conv definitions for the lane scatter unit.
// Holds the lane count, lane index width, the 2-state FSM encoding
// (kept as plain constants so legacy code comparing raw bits still works),
// the all-lanes-written mask and a one-hot lane decode helper.
package lane_scatter_16_pkg;

  localparam int unsigned LANES      = 16;
  localparam int unsigned LANE_IDX_W = 4;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  localparam logic [LANES-1:0] MASK_FULL = 16'hFFFF;

  function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_IDX_W-1:0] idx);
    logic [LANES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/lane_scatter_16_lane_reg_bank.sv
// lane_reg_bank: 16 lane registers of DATA_WIDTH bits.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset (clears all lanes)
//   we_i      : write enable
//   widx_i    : 4-bit lane index written when we_i is high
//   wdata_i   : signed word stored bit-exact
//   rdata_o   : flattened read bus, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
module lane_reg_bank
  import lane_scatter_16_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we_i,
  input  logic [LANE_IDX_W-1:0]         widx_i,
  input  logic signed [DATA_WIDTH-1:0]  wdata_i,
  output logic [LANES*DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] lane_q [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
      end
    end else if (we_i) begin
      lane_q[widx_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
    end
  end

endmodule

// File: rtl/lane_scatter_16.sv
// lane_scatter_16: serial-to-parallel scatter into 16 lane registers.
// One signed word is accepted per in_valid/in_ready handshake and steered to
// lane ptr (mode=0, round-robin) or lane in_sel (mode=1). Once every lane has
// been written the full vector is offered on frame_valid/frame_ready.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   mode                   : 0 sequential, 1 addressed (stable per frame)
//   in_valid/in_ready      : input handshake; in_data word, in_sel lane (addressed)
//   frame_valid/ready      : output handshake; frame_data flattened lanes
//   lane_mask              : lanes written in the current frame
//   err_overwrite          : sticky addressed-mode overwrite flag
// Optional: define LANE_SCATTER_OVERWRITE_CHECK_EN to enable err_overwrite;
// otherwise it is tied low.
module lane_scatter_16
  import lane_scatter_16_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic [LANE_IDX_W-1:0]         in_sel,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [LANES*DATA_WIDTH-1:0]   frame_data,
  output logic [LANES-1:0]              lane_mask,
  output logic                          err_overwrite
);

  logic [0:0]            state_q, state_d;
  logic [LANE_IDX_W-1:0] ptr_q, ptr_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic [LANE_IDX_W-1:0] tgt;
  logic [LANES-1:0]      mask_wr;
  logic                  accept;

  assign in_ready    = (state_q == ST_FILL);
  assign frame_valid = (state_q == ST_FULL);
  assign lane_mask   = mask_q;
  assign accept      = in_valid && in_ready;
  assign tgt         = mode ? in_sel : ptr_q;
  // Mask including the write happening this cycle decides completion.
  assign mask_wr     = mask_q | lane_onehot(tgt);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    if (state_q == ST_FILL) begin
      if (accept) begin
        mask_d = mask_wr;
        if (!mode) begin
          ptr_d = ptr_q + LANE_IDX_W'(1);
        end
        if (mask_wr == MASK_FULL) begin
          state_d = ST_FULL;
        end
      end
    end else begin
      if (frame_ready) begin
        mask_d  = '0;
        ptr_d   = '0;
        state_d = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      ptr_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
    end
  end

  lane_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (accept),
    .widx_i  (tgt),
    .wdata_i (in_data),
    .rdata_o (frame_data)
  );

`ifdef LANE_SCATTER_OVERWRITE_CHECK_EN
  logic err_q, err_d;

  assign err_d = err_q | (accept & mode & mask_q[tgt]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_overwrite = err_q;
`else
  assign err_overwrite = 1'b0;
`endif

endmodule
